// File: rtl/parser_pkg.sv
// parser_pipe shared definitions.
// Config word map and the rule entry layout.
package parser_pkg;

  localparam logic [7:0] WORD_VALID = 8'd0;
  localparam logic [7:0] WORD_VALUE = 8'd1;
  localparam logic [7:0] WORD_MASK  = 8'd2;
  localparam logic [7:0] WORD_KOFF  = 8'd3;

  localparam logic [7:0] TYPE_OFF_ENTRY = 8'hFF;

  typedef struct packed {
    logic        valid;
    logic [63:0] value;
    logic [63:0] mask;
    logic [63:0] koff;
  } rule_t;

  function automatic logic [63:0] low_mask(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/parser_field_extract.sv
// Offset-indexed field mux.
// Field k sits at the MSB end (network order).
module parser_field_extract #(
  parameter int PHV_WIDTH   = 1024,
  parameter int FIELD_WIDTH = 8,
  parameter int OFF_WIDTH   = $clog2(PHV_WIDTH/FIELD_WIDTH)
) (
  input  logic [PHV_WIDTH-1:0]   phv,
  input  logic [OFF_WIDTH-1:0]   off,
  output logic [FIELD_WIDTH-1:0] field
);

  localparam int NF = PHV_WIDTH / FIELD_WIDTH;

  logic [FIELD_WIDTH-1:0] f [NF];

  for (genvar k = 0; k < NF; k++) begin : g_f
    assign f[k] = phv[PHV_WIDTH-1-k*FIELD_WIDTH -: FIELD_WIDTH];
  end

  // select the addressed field
  always_comb field = f[off];

endmodule

// File: rtl/parser_pipe.sv
// 3-stage PHV parser: type extract, ternary rule lookup,
// key extract; staged rule config with atomic commit.
module parser_pipe #(
  parameter int PHV_WIDTH         = 1024,
  parameter int TYPE_WIDTH        = 8,
  parameter int TYPE_NUM          = 4,
  parameter int KEY_FIELD_WIDTH   = 16,
  parameter int KEY_FIELD_NUM     = 8,
  parameter int RULE_NUM          = 8,
  parameter int TYPE_OFFSET_WIDTH =
    $clog2(PHV_WIDTH/TYPE_WIDTH),
  parameter int KEY_OFFSET_WIDTH  =
    $clog2(PHV_WIDTH/KEY_FIELD_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rule_wren,
  input  logic                 i_rule_rden,
  input  logic [31:0]          i_rule_addr,
  input  logic [63:0]          i_rule_wdata,
  output logic                 o_rule_rdata_valid,
  output logic [63:0]          o_rule_rdata,
  input  logic                 i_phv_in_valid,
  output logic                 o_phv_in_ready,
  input  logic [PHV_WIDTH-1:0] i_phv_in,
  output logic                 o_phv_out_valid,
  input  logic                 i_phv_out_ready,
  output logic [PHV_WIDTH-1:0] o_phv_out,
  output logic [KEY_FIELD_NUM*KEY_FIELD_WIDTH-1:0] o_key,
  output logic                 o_hit,
  output logic [7:0]           o_rule_idx
);

  import parser_pkg::*;

  localparam int TW  = TYPE_NUM * TYPE_WIDTH;
  localparam int KW  = KEY_FIELD_NUM * KEY_FIELD_WIDTH;
  localparam int TOW = TYPE_NUM * TYPE_OFFSET_WIDTH;
  localparam int KOW = KEY_FIELD_NUM * KEY_OFFSET_WIDTH;

  localparam logic [63:0] VMASK = low_mask(TW);
  localparam logic [63:0] KMASK = low_mask(KOW);

  logic [7:0] entry;
  logic [7:0] word;
  logic       hi_zero;
  logic       is_toff;

  assign entry   = i_rule_addr[15:8];
  assign word    = i_rule_addr[7:0];
  assign hi_zero = i_rule_addr[31:16] == 16'd0;
  assign is_toff = hi_zero && entry == TYPE_OFF_ENTRY
                   && word == WORD_VALID;

  rule_t          act_q [RULE_NUM];
  rule_t          stg_q [RULE_NUM];
  logic [TOW-1:0] toff_q;

  // config writes: stage words 1..3, word0 commits
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        act_q[r] <= '0;
        stg_q[r] <= '0;
      end
      toff_q <= '0;
    end else if (i_rule_wren) begin
      if (is_toff) toff_q <= i_rule_wdata[TOW-1:0];
      for (int r = 0; r < RULE_NUM; r++) begin
        if (hi_zero && entry == 8'(r)) begin
          unique case (1'b1)
            (word == WORD_VALID): begin
              act_q[r].valid <= i_rule_wdata[0];
              act_q[r].value <= stg_q[r].value;
              act_q[r].mask  <= stg_q[r].mask;
              act_q[r].koff  <= stg_q[r].koff;
            end
            (word == WORD_VALUE):
              stg_q[r].value <= i_rule_wdata & VMASK;
            (word == WORD_MASK):
              stg_q[r].mask <= i_rule_wdata & VMASK;
            (word == WORD_KOFF):
              stg_q[r].koff <= i_rule_wdata & KMASK;
            default: ;
          endcase
        end
      end
    end
  end

  logic [63:0] rd_c;

  // read mux over the committed state only
  always_comb begin
    rd_c = '0;
    if (is_toff) rd_c = 64'(toff_q);
    for (int r = 0; r < RULE_NUM; r++) begin
      if (hi_zero && entry == 8'(r)) begin
        unique case (1'b1)
          (word == WORD_VALID): rd_c = 64'(act_q[r].valid);
          (word == WORD_VALUE): rd_c = act_q[r].value;
          (word == WORD_MASK):  rd_c = act_q[r].mask;
          (word == WORD_KOFF):  rd_c = act_q[r].koff;
          default: ;
        endcase
      end
    end
  end

  // one-cycle read response
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
    end else begin
      o_rule_rdata_valid <= i_rule_rden;
      if (i_rule_rden) o_rule_rdata <= rd_c;
    end
  end

  logic en;
  assign en = !o_phv_out_valid || i_phv_out_ready;
  assign o_phv_in_ready = en;

  logic [TW-1:0] types_c;

  for (genvar i = 0; i < TYPE_NUM; i++) begin : g_type
    parser_field_extract #(
      .PHV_WIDTH   (PHV_WIDTH),
      .FIELD_WIDTH (TYPE_WIDTH),
      .OFF_WIDTH   (TYPE_OFFSET_WIDTH)
    ) u_type (
      .phv   (i_phv_in),
      .off   (toff_q[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH]),
      .field (types_c[TW-1-i*TYPE_WIDTH -: TYPE_WIDTH])
    );
  end

  logic                 v1;
  logic [PHV_WIDTH-1:0] phv1;
  logic [TW-1:0]        types1;

  // S1: capture PHV and its type fields
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1     <= 1'b0;
      phv1   <= '0;
      types1 <= '0;
    end else if (en) begin
      v1     <= i_phv_in_valid;
      phv1   <= i_phv_in;
      types1 <= types_c;
    end
  end

  logic           hit_c;
  logic [7:0]     idx_c;
  logic [KOW-1:0] koff_c;

  // ternary lookup, lowest index wins
  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    koff_c = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (act_q[r].valid &&
          (((64'(types1) ^ act_q[r].value)
            & act_q[r].mask) == 64'd0)) begin
        hit_c  = 1'b1;
        idx_c  = 8'(r);
        koff_c = act_q[r].koff[KOW-1:0];
      end
    end
  end

  logic                 v2;
  logic [PHV_WIDTH-1:0] phv2;
  logic                 hit2;
  logic [7:0]           idx2;
  logic [KOW-1:0]       koff2;

  // S2: register lookup result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v2    <= 1'b0;
      phv2  <= '0;
      hit2  <= 1'b0;
      idx2  <= '0;
      koff2 <= '0;
    end else if (en) begin
      v2    <= v1;
      phv2  <= phv1;
      hit2  <= hit_c;
      idx2  <= idx_c;
      koff2 <= koff_c;
    end
  end

  logic [KW-1:0] key_c;

  for (genvar k = 0; k < KEY_FIELD_NUM; k++) begin : g_key
    parser_field_extract #(
      .PHV_WIDTH   (PHV_WIDTH),
      .FIELD_WIDTH (KEY_FIELD_WIDTH),
      .OFF_WIDTH   (KEY_OFFSET_WIDTH)
    ) u_key (
      .phv   (phv2),
      .off   (koff2[k*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH]),
      .field (key_c[k*KEY_FIELD_WIDTH +: KEY_FIELD_WIDTH])
    );
  end

  // S3: output register, key zeroed on miss
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_phv_out_valid <= 1'b0;
      o_phv_out       <= '0;
      o_key           <= '0;
      o_hit           <= 1'b0;
      o_rule_idx      <= '0;
    end else if (en) begin
      o_phv_out_valid <= v2;
      o_phv_out       <= phv2;
      o_key           <= hit2 ? key_c : '0;
      o_hit           <= hit2;
      o_rule_idx      <= hit2 ? idx2 : 8'd0;
    end
  end

endmodule

// File: tb/tb_parser_pipe.sv
// Directed bench for parser_pipe.
// Hand-computed expectations, one checking task.
module tb_parser_pipe;

  localparam int PW = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wren, rden;
  logic [31:0]   addr;
  logic [63:0]   wdata;
  logic          rdata_valid;
  logic [63:0]   rdata;
  logic          in_valid, in_ready;
  logic [PW-1:0] phv_in;
  logic          out_valid, out_ready;
  logic [PW-1:0] phv_out;
  logic [127:0]  key;
  logic          hit;
  logic [7:0]    idx;

  always #5 clk = ~clk;

  parser_pipe dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rule_wren        (wren),
    .i_rule_rden        (rden),
    .i_rule_addr        (addr),
    .i_rule_wdata       (wdata),
    .o_rule_rdata_valid (rdata_valid),
    .o_rule_rdata       (rdata),
    .i_phv_in_valid     (in_valid),
    .o_phv_in_ready     (in_ready),
    .i_phv_in           (phv_in),
    .o_phv_out_valid    (out_valid),
    .i_phv_out_ready    (out_ready),
    .o_phv_out          (phv_out),
    .o_key              (key),
    .o_hit              (hit),
    .o_rule_idx         (idx)
  );

  localparam logic [63:0] TOFF =
    64'd12 | (64'd13 << 7) | (64'd14 << 14) | (64'd15 << 21);
  localparam logic [63:0] KOFF_SEQ =
    (64'd1 << 6) | (64'd2 << 12) | (64'd3 << 18)
    | (64'd4 << 24) | (64'd5 << 30) | (64'd6 << 36)
    | (64'd7 << 42);
  localparam logic [63:0] KOFF_ONE = 64'h0410_4104_1041;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_phv(
      input logic [7:0] base, input logic [31:0] typ);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < 128; i++)
      p[PW-1-8*i -: 8] = base + 8'(i);
    p[PW-1-8*12 -: 32] = typ;
    return p;
  endfunction

  task automatic cfg_wr(input logic [7:0] e,
                        input logic [7:0] w,
                        input logic [63:0] d);
    @(negedge clk);
    wren  = 1'b1;
    addr  = {16'h0, e, w};
    wdata = d;
    @(negedge clk);
    wren  = 1'b0;
  endtask

  task automatic cfg_rd(input string tag,
                        input logic [7:0] e,
                        input logic [7:0] w,
                        input logic [63:0] exp);
    @(negedge clk);
    rden = 1'b1;
    addr = {16'h0, e, w};
    @(negedge clk);
    rden = 1'b0;
    chk({tag, "_vld"}, 128'(rdata_valid), 128'd1);
    chk(tag, 128'(rdata), 128'(exp));
  endtask

  task automatic send(input string tag,
                      input logic [31:0] typ,
                      input logic [7:0] base,
                      input logic exp_hit,
                      input logic [7:0] exp_idx,
                      input logic [127:0] exp_key);
    logic [PW-1:0] p;
    int n;
    p = mk_phv(base, typ);
    @(negedge clk);
    in_valid = 1'b1;
    phv_in   = p;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 8);
    chk({tag, "_lat"}, 128'(n), 128'd3);
    chk({tag, "_phv"}, 128'(phv_out == p), 128'd1);
    chk({tag, "_hit"}, 128'(hit), 128'(exp_hit));
    chk({tag, "_idx"}, 128'(idx), 128'(exp_idx));
    chk({tag, "_key"}, key, exp_key);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [PW-1:0] bp [5];
  logic [PW-1:0] held;
  int            tx, rx;
  logic          stray;

  initial begin
    rst_n     = 1'b0;
    wren      = 1'b0;
    rden      = 1'b0;
    addr      = '0;
    wdata     = '0;
    in_valid  = 1'b0;
    phv_in    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_hit", 128'(hit), 128'd0);
    chk("rst_idx", 128'(idx), 128'd0);
    chk("rst_key", key, 128'd0);
    chk("rst_phv", 128'(phv_out == '0), 128'd1);
    chk("rst_rvld", 128'(rdata_valid), 128'd0);
    chk("rst_rdata", 128'(rdata), 128'd0);
    rst_n = 1'b1;

    // basic match on rule 0, key = fields 0..7
    cfg_wr(8'hFF, 8'd0, TOFF);
    cfg_wr(8'd0, 8'd1, 64'h0800_4500);
    cfg_wr(8'd0, 8'd2, 64'hFFFF_FFFF);
    cfg_wr(8'd0, 8'd3, KOFF_SEQ);
    cfg_wr(8'd0, 8'd0, 64'd1);
    send("r0", 32'h0800_4500, 8'h00, 1'b1, 8'd0,
         128'h4500_0800_0a0b_0809_0607_0405_0203_0001);
    send("miss", 32'h86DD_6000, 8'h20, 1'b0, 8'd0, 128'd0);

    // priority: rule 1 exact, rule 3 wildcard
    cfg_wr(8'd1, 8'd1, 64'h86DD_6000);
    cfg_wr(8'd1, 8'd2, 64'hFFFF_FFFF);
    cfg_wr(8'd1, 8'd0, 64'd1);
    cfg_wr(8'd3, 8'd0, 64'd1);
    send("prio1", 32'h86DD_6000, 8'h40, 1'b1, 8'd1,
         {8{16'h4041}});
    cfg_wr(8'd1, 8'd0, 64'd0);
    send("prio3", 32'h86DD_6000, 8'h40, 1'b1, 8'd3,
         {8{16'h4041}});

    // back-to-back with 5-cycle downstream stall
    for (int i = 0; i < 5; i++)
      bp[i] = mk_phv(8'(16*i + 1), 32'hC0DE_0000 + i);
    tx = 0;
    rx = 0;
    held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      in_valid  = tx < 5;
      phv_in    = bp[tx < 5 ? tx : 0];
      out_ready = cyc >= 8;
      #1;
      if (cyc == 3) held = phv_out;
      if (cyc == 5)
        chk("bp_full_ready", 128'(in_ready), 128'd0);
      if (cyc == 7)
        chk("bp_hold", 128'(phv_out == held), 128'd1);
      if (in_valid && in_ready) tx++;
      if (out_valid && out_ready) begin
        if (rx < 5) begin
          chk("bp_order", 128'(phv_out == bp[rx]), 128'd1);
          chk("bp_idx", 128'(idx), 128'd3);
        end
        rx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_tx", 128'(tx), 128'd5);
    chk("bp_rx", 128'(rx), 128'd5);

    // staging is invisible until word0 commit
    cfg_wr(8'd2, 8'd1, 64'h0A0B_0C0D);
    cfg_wr(8'd2, 8'd2, 64'hFFFF_FFFF);
    cfg_wr(8'd2, 8'd0, 64'd1);
    send("stg_a", 32'h0A0B_0C0D, 8'h50, 1'b1, 8'd2,
         {8{16'h5051}});
    cfg_wr(8'd2, 8'd1, 64'h1122_3344);
    cfg_wr(8'd2, 8'd3, KOFF_ONE);
    cfg_rd("stg_rd_w1", 8'd2, 8'd1, 64'h0A0B_0C0D);
    cfg_rd("stg_rd_w3", 8'd2, 8'd3, 64'd0);
    send("stg_old", 32'h0A0B_0C0D, 8'h60, 1'b1, 8'd2,
         {8{16'h6061}});
    send("stg_new_pre", 32'h1122_3344, 8'h70, 1'b1, 8'd3,
         {8{16'h7071}});
    cfg_wr(8'd2, 8'd0, 64'd1);
    send("cmt_new", 32'h1122_3344, 8'h70, 1'b1, 8'd2,
         {8{16'h7273}});
    send("cmt_old", 32'h0A0B_0C0D, 8'h80, 1'b1, 8'd3,
         {8{16'h8081}});
    cfg_rd("cmt_rd_w1", 8'd2, 8'd1, 64'h1122_3344);
    cfg_rd("cmt_rd_w3", 8'd2, 8'd3, KOFF_ONE);

    // read-back and unmapped space
    cfg_rd("rd_toff", 8'hFF, 8'd0, TOFF);
    @(negedge clk);
    chk("rd_vld_drop", 128'(rdata_valid), 128'd0);
    cfg_rd("rd_unmapped_e", 8'd8, 8'd1, 64'd0);
    cfg_rd("rd_unmapped_w", 8'd2, 8'd4, 64'd0);

    // same-cycle write and read of one word
    @(negedge clk);
    wren  = 1'b1;
    rden  = 1'b1;
    addr  = {16'h0, 8'd2, 8'd0};
    wdata = 64'd0;
    @(negedge clk);
    wren = 1'b0;
    rden = 1'b0;
    chk("rw_same_old", 128'(rdata), 128'd1);
    cfg_rd("rw_same_new", 8'd2, 8'd0, 64'd0);

    // reset with two PHVs in flight
    @(negedge clk);
    in_valid = 1'b1;
    phv_in   = mk_phv(8'h00, 32'h0800_4500);
    @(negedge clk);
    phv_in   = mk_phv(8'h10, 32'h0800_4500);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_hit", 128'(hit), 128'd0);
    stray = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) stray = 1'b1;
      @(negedge clk);
    end
    chk("mid_rst_no_out", 128'(stray), 128'd0);
    cfg_rd("mid_rst_r0", 8'd0, 8'd0, 64'd0);
    cfg_rd("mid_rst_toff", 8'hFF, 8'd0, 64'd0);
    send("post_rst", 32'h0800_4500, 8'h00, 1'b0, 8'd0,
         128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
